// File: rtl/sdf_bitrev_reorder.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | sdf_bitrev_reorder: ping-pong bit-reversed to natural order reorder buf |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sdf_bitrev_reorder #(
  parameter int DATA_W = 16,
  parameter int LOG2_N = 6
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              di_en,
  input  logic [DATA_W-1:0] di_re,
  input  logic [DATA_W-1:0] di_im,
  output logic              do_en,
  output logic [DATA_W-1:0] do_re,
  output logic [DATA_W-1:0] do_im,
  output logic [LOG2_N-1:0] do_idx,
  output logic              do_last
);

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } state_t;

  function automatic logic [LOG2_N-1:0] bitrev(input logic [LOG2_N-1:0] x);
    logic [LOG2_N-1:0] r;
    r = '0;
    for (int i = 0; i < LOG2_N; i++) begin
      r[i] = x[LOG2_N-1-i];
    end
    return r;
  endfunction

  logic [2*DATA_W-1:0] mem_q [0:2*(2**LOG2_N)-1];

  logic [LOG2_N-1:0] wr_cnt_q;
  logic              wr_bank_q;
  logic [LOG2_N-1:0] rd_cnt_q;
  logic              rd_bank_q;
  logic [1:0]        full_q;
  logic [1:0]        full_d;
  state_t            state_q;
  logic              wr_done;
  logic              rd_done;

  assign wr_done = di_en && (wr_cnt_q == '1);
  assign rd_done = (state_q == READ) && (rd_cnt_q == '1);

  // Banks never collide: a read finishes before the other bank fills
  always_comb begin
    full_d = full_q;
    if (rd_done) full_d[rd_bank_q] = 1'b0;
    if (wr_done) full_d[wr_bank_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (di_en) begin
      mem_q[{wr_bank_q, bitrev(wr_cnt_q)}] <= {di_re, di_im};
    end
  end

  // A gap in di_en discards the partial frame and rewinds to slot 0
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_cnt_q  <= '0;
      wr_bank_q <= 1'b0;
    end else if (di_en) begin
      wr_cnt_q <= wr_cnt_q + 1'b1;
      if (wr_done) wr_bank_q <= ~wr_bank_q;
    end else begin
      wr_cnt_q <= '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      rd_cnt_q  <= '0;
      rd_bank_q <= 1'b0;
      full_q    <= 2'b00;
      do_en     <= 1'b0;
      do_re     <= '0;
      do_im     <= '0;
      do_idx    <= '0;
      do_last   <= 1'b0;
    end else begin
      full_q <= full_d;
      case (state_q)
        IDLE: begin
          do_en   <= 1'b0;
          do_re   <= '0;
          do_im   <= '0;
          do_idx  <= '0;
          do_last <= 1'b0;
          if (full_q[rd_bank_q]) begin
            state_q  <= READ;
            rd_cnt_q <= '0;
          end
        end
        READ: begin
          do_en            <= 1'b1;
          {do_re, do_im}   <= mem_q[{rd_bank_q, rd_cnt_q}];
          do_idx           <= rd_cnt_q;
          do_last          <= (rd_cnt_q == '1);
          rd_cnt_q         <= rd_cnt_q + 1'b1;
          if (rd_done) begin
            rd_bank_q <= ~rd_bank_q;
            if (!full_q[~rd_bank_q]) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sdf_bitrev_reorder.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sdf_bitrev_reorder: random-stimulus bench, N=8 and N=64 instances     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_sdf_bitrev_reorder;

  logic        clk = 1'b0;
  logic        rstn;
  logic        di_en;
  logic        sel;
  logic [15:0] di_re;
  logic [15:0] di_im;

  logic        do_en8,  last8;
  logic [15:0] re8, im8;
  logic [2:0]  idx8;
  logic        do_en64, last64;
  logic [15:0] re64, im64;
  logic [5:0]  idx64;

  always #5 clk = ~clk;

  sdf_bitrev_reorder #(.DATA_W(16), .LOG2_N(3)) u8 (
    .clk(clk), .rstn(rstn), .di_en(di_en & ~sel), .di_re(di_re), .di_im(di_im),
    .do_en(do_en8), .do_re(re8), .do_im(im8), .do_idx(idx8), .do_last(last8)
  );

  sdf_bitrev_reorder #(.DATA_W(16), .LOG2_N(6)) u64 (
    .clk(clk), .rstn(rstn), .di_en(di_en & sel), .di_re(di_re), .di_im(di_im),
    .do_en(do_en64), .do_re(re64), .do_im(im64), .do_idx(idx64), .do_last(last64)
  );

  typedef struct {
    int          cyc;
    logic [15:0] re;
    logic [15:0] im;
    logic [5:0]  idx;
    logic        last;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   mon_on = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int rev(input int x, input int bits);
    int r = 0;
    int v = x;
    for (int i = 0; i < bits; i++) begin
      r = r * 2 + v % 2;
      v = v / 2;
    end
    return r;
  endfunction

  // Every negedge: either the scheduled sample or an all-zero idle output
  always @(negedge clk) begin
    logic [39:0] obs, expv;
    exp_t e;
    if (mon_on) begin
      obs = sel ? {do_en64, re64, im64, idx64, last64}
                : {do_en8, re8, im8, 3'b000, idx8, last8};
      expv = '0;
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        expv = {1'b1, e.re, e.im, e.idx, e.last};
      end
      total++;
      assert (obs === expv) else begin
        bad++;
        $error("FAIL out cyc=%0d observed=%h expected=%h", cyc, obs, expv);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      di_en = 1'b0;
      di_re = '0;
      di_im = '0;
    end
  endtask

  // mode 0: re=bitrev(p), 1: im=-re, 2: 0x7FFF/0x8000 extremes, 3: random
  task automatic send_frame(input int n, input int mode, output int last_cyc);
    logic [15:0] sre[64];
    logic [15:0] sim[64];
    int bits;
    exp_t e;
    bits = (n == 64) ? 6 : 3;
    last_cyc = 0;
    for (int p = 0; p < n; p++) begin
      @(negedge clk);
      di_en = 1'b1;
      case (mode)
        0: begin di_re = 16'(rev(p, bits)); di_im = 16'($urandom); end
        1: begin di_re = 16'(rev(p, bits)); di_im = -di_re; end
        2: begin di_re = (p % 2 == 1) ? 16'h8000 : 16'h7FFF; di_im = 16'($urandom); end
        default: begin di_re = 16'($urandom); di_im = 16'($urandom); end
      endcase
      sre[p] = di_re;
      sim[p] = di_im;
      if (p == n - 1) last_cyc = cyc + 1;
    end
    // Natural index k holds the sample that arrived at position bitrev(k)
    for (int k = 0; k < n; k++) begin
      e.cyc  = last_cyc + 2 + k;
      e.re   = sre[rev(k, bits)];
      e.im   = sim[rev(k, bits)];
      e.idx  = 6'(k);
      e.last = (k == n - 1);
      q.push_back(e);
    end
  endtask

  task automatic fragment(input int m);
    for (int p = 0; p < m; p++) begin
      @(negedge clk);
      di_en = 1'b1;
      di_re = 16'($urandom);
      di_im = 16'($urandom);
    end
  endtask

  initial begin
    int t;
    rstn  = 1'b0;
    di_en = 1'b0;
    sel   = 1'b0;
    di_re = '0;
    di_im = '0;
    repeat (3) @(negedge clk);
    total++;
    assert ({do_en8, re8, im8, idx8, last8} === 36'd0) else begin
      bad++;
      $error("FAIL reset8 observed=%h expected=0", {do_en8, re8, im8, idx8, last8});
    end
    total++;
    assert ({do_en64, re64, im64, idx64, last64} === 40'd0) else begin
      bad++;
      $error("FAIL reset64 observed=%h expected=0", {do_en64, re64, im64, idx64, last64});
    end
    rstn   = 1'b1;
    mon_on = 1'b1;

    // single frame, ramp output
    send_frame(8, 0, t);
    idle(12);

    // three back-to-back frames
    send_frame(8, 1, t);
    send_frame(8, 1, t);
    send_frame(8, 1, t);
    idle(12);

    // aborted fragment then a full frame
    fragment(5);
    idle(1);
    send_frame(8, 3, t);
    idle(12);

    // two frames separated by a long gap
    send_frame(8, 3, t);
    idle(20);
    send_frame(8, 3, t);
    idle(12);

    // reset while idx 3 is on the output
    send_frame(8, 0, t);
    idle(1);
    repeat (5) @(negedge clk);
    #2 rstn = 1'b0;
    q.delete();
    #1;
    total++;
    assert ({do_en8, re8, im8, idx8, last8} === 36'd0) else begin
      bad++;
      $error("FAIL async_reset observed=%h expected=0", {do_en8, re8, im8, idx8, last8});
    end
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    send_frame(8, 3, t);
    idle(12);

    // N=64 extremes and random, back-to-back
    sel = 1'b1;
    idle(2);
    send_frame(64, 2, t);
    send_frame(64, 3, t);
    idle(140);

    total++;
    assert (q.size() === 0) else begin
      bad++;
      $error("FAIL drain observed=%0d expected=0", q.size());
    end
    mon_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
